ddr_req_arbiter: RTL and testbench

DDR_REQ_ARBITER -- requirements
Module: ddr_req_arbiter

---
 rtl/ddr_pkg.sv | 22 ++
 rtl/ddr_req_arbiter_if.sv | 43 ++++
 rtl/ddr_refresh_timer.sv | 46 ++++
 rtl/ddr_req_arbiter.sv | 127 ++++++++++++
 tb/tb_ddr_req_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_pkg.sv
// Shared types for the DDR request arbiter: controller command codes, FSM states
// and the mapping from a requester's access type to its controller command.
package ddr_pkg;

    typedef enum logic [1:0] {
        CMD_NOP     = 2'b00,
        CMD_READ    = 2'b01,
        CMD_WRITE   = 2'b10,
        CMD_REFRESH = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE_REQ = 2'd1,
        ST_ISSUE_REF = 2'd2
    } state_e;

    function automatic cmd_e rw_to_cmd(input logic rw);
        return rw ? CMD_WRITE : CMD_READ;
    endfunction

endpackage

// File: rtl/ddr_req_arbiter_if.sv
// Signal bundle between two requesters, the arbiter and the DDR controller.
// Handshake: REQn is a level held until GNTn pulses; COMMAND and its fields are valid
// while BUSY is high and are consumed at the rising edge where ACCEPTED is high.
interface ddr_req_arbiter_if;
    import ddr_pkg::*;

    logic        REQ0;
    logic        REQ1;
    logic        RW0;
    logic        RW1;
    logic [1:0]  BA0;
    logic [1:0]  BA1;
    logic [22:0] ADDR0;
    logic [22:0] ADDR1;
    logic [1:0]  BL0;
    logic [1:0]  BL1;
    logic        WL0;
    logic        WL1;
    logic        GNT0;
    logic        GNT1;
    logic [1:0]  COMMAND;
    logic [1:0]  BA_IN;
    logic [22:0] ADDR_IN;
    logic [1:0]  BL;
    logic        WRITE_LENGTH;
    logic        ACCEPTED;
    logic        GRANT_ID;
    logic        BUSY;
    state_e      STATE_DBG;

    modport slave (
        input  REQ0, REQ1, RW0, RW1, BA0, BA1, ADDR0, ADDR1, BL0, BL1, WL0, WL1, ACCEPTED,
        output GNT0, GNT1, COMMAND, BA_IN, ADDR_IN, BL, WRITE_LENGTH, GRANT_ID, BUSY,
               STATE_DBG
    );

    modport master (
        output REQ0, REQ1, RW0, RW1, BA0, BA1, ADDR0, ADDR1, BL0, BL1, WL0, WL1, ACCEPTED,
        input  GNT0, GNT1, COMMAND, BA_IN, ADDR_IN, BL, WRITE_LENGTH, GRANT_ID, BUSY,
               STATE_DBG
    );

endinterface

// File: rtl/ddr_refresh_timer.sv
// Free-running refresh interval counter feeding a saturating count of refreshes
// that are owed to the DRAM but not yet accepted by the controller.
module ddr_refresh_timer #(
    parameter int REFRESH_INTERVAL = 780,
    parameter int REF_PEND_MAX     = 3
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic ref_done_i,
    output logic ref_pend_nz_o
);
    localparam int CW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int PW = (REF_PEND_MAX > 0) ? $clog2(REF_PEND_MAX + 1) : 1;
    localparam logic [CW-1:0] RELOAD   = CW'(REFRESH_INTERVAL - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(REF_PEND_MAX);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          expire;

    assign expire = (cnt_q == '0);

    always_comb begin
        cnt_d  = expire ? RELOAD : cnt_q - CW'(1);
        pend_d = pend_q;
        // An expiry and a completed refresh in the same cycle cancel each other.
        if (expire && !ref_done_i) begin
            if (pend_q != PEND_MAX) pend_d = pend_q + PW'(1);
        end else if (ref_done_i && !expire) begin
            if (pend_q != '0) pend_d = pend_q - PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= RELOAD;
            pend_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign ref_pend_nz_o = (pend_q != '0);

endmodule

// File: rtl/ddr_req_arbiter.sv
// Two-requester round-robin arbiter in front of a DDR controller; owed refreshes
// take priority over requests and every command is followed by a NOP cycle.
module ddr_req_arbiter
    import ddr_pkg::*;
#(
    parameter int REFRESH_INTERVAL = 780,
    parameter int REF_PEND_MAX     = 3
) (
    input  logic             DDR_CLK,
    input  logic             RST_N,
    ddr_req_arbiter_if.slave bus
);
    state_e      state_q, state_d;
    cmd_e        cmd_q, cmd_d;
    logic [1:0]  ba_q, ba_d;
    logic [22:0] addr_q, addr_d;
    logic [1:0]  bl_q, bl_d;
    logic        wl_q, wl_d;
    logic        gid_q, gid_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        last_q, last_d;

    logic        ref_pend_nz;
    logic        ref_done;
    logic [1:0]  req_eff;
    logic        winner;

    assign ref_done = (state_q == ST_ISSUE_REF) && bus.ACCEPTED;

    ddr_refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL),
        .REF_PEND_MAX     (REF_PEND_MAX)
    ) u_refresh_timer (
        .clk_i         (DDR_CLK),
        .rst_n_i       (RST_N),
        .ref_done_i    (ref_done),
        .ref_pend_nz_o (ref_pend_nz)
    );

    // A requester whose grant pulse is on the wire has not yet had a chance to drop REQ.
    assign req_eff = {bus.REQ1, bus.REQ0} & ~gnt_q;
    assign winner  = (req_eff == 2'b11) ? ~last_q : req_eff[1];

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        ba_d    = ba_q;
        addr_d  = addr_q;
        bl_d    = bl_q;
        wl_d    = wl_q;
        gid_d   = gid_q;
        last_d  = last_q;
        gnt_d   = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (ref_pend_nz) begin
                    state_d = ST_ISSUE_REF;
                    cmd_d   = CMD_REFRESH;
                end else if (req_eff != 2'b00) begin
                    state_d = ST_ISSUE_REQ;
                    cmd_d   = rw_to_cmd(winner ? bus.RW1 : bus.RW0);
                    ba_d    = winner ? bus.BA1   : bus.BA0;
                    addr_d  = winner ? bus.ADDR1 : bus.ADDR0;
                    bl_d    = winner ? bus.BL1   : bus.BL0;
                    wl_d    = winner ? bus.WL1   : bus.WL0;
                    gid_d   = winner;
                end else begin
                    cmd_d = CMD_NOP;
                end
            end
            ST_ISSUE_REQ: begin
                if (bus.ACCEPTED) begin
                    state_d        = ST_IDLE;
                    cmd_d          = CMD_NOP;
                    gnt_d[gid_q]   = 1'b1;
                    last_d         = gid_q;
                end
            end
            ST_ISSUE_REF: begin
                if (bus.ACCEPTED) begin
                    state_d = ST_IDLE;
                    cmd_d   = CMD_NOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cmd_d   = CMD_NOP;
            end
        endcase
    end

    always_ff @(posedge DDR_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_NOP;
            ba_q    <= '0;
            addr_q  <= '0;
            bl_q    <= '0;
            wl_q    <= 1'b0;
            gid_q   <= 1'b0;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
            bl_q    <= bl_d;
            wl_q    <= wl_d;
            gid_q   <= gid_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    assign bus.COMMAND      = cmd_q;
    assign bus.BA_IN        = ba_q;
    assign bus.ADDR_IN      = addr_q;
    assign bus.BL           = bl_q;
    assign bus.WRITE_LENGTH = wl_q;
    assign bus.GRANT_ID     = gid_q;
    assign bus.GNT0         = gnt_q[0];
    assign bus.GNT1         = gnt_q[1];
    assign bus.BUSY         = (state_q != ST_IDLE);
    assign bus.STATE_DBG    = state_q;

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Bench for ddr_req_arbiter: directed scenarios and a randomized run, each cycle
// compared against a transaction-level model of the arbiter's externally visible behaviour.
module tb_ddr_req_arbiter;
    import ddr_pkg::*;

    localparam int RI   = 16;
    localparam int PMAX = 3;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    // Reference model: one outstanding command record plus an owed-refresh count.
    int          m_edge;
    int          m_pend;
    bit          m_active;
    bit          m_is_ref;
    bit          m_last;
    logic [1:0]  m_cmd;
    logic [1:0]  m_ba;
    logic [22:0] m_addr;
    logic [1:0]  m_bl;
    logic        m_wl;
    logic        m_gid;
    logic [1:0]  m_gnt;

    logic [0:0]  exp_q[$];
    logic [1:0]  prev_cmd;
    int          ref_cnt;

    ddr_req_arbiter_if bus_if ();

    ddr_req_arbiter #(
        .REFRESH_INTERVAL (RI),
        .REF_PEND_MAX     (PMAX)
    ) dut (
        .DDR_CLK (clk),
        .RST_N   (rst_n),
        .bus     (bus_if)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] obs_vec();
        return {bus_if.COMMAND, bus_if.BA_IN, bus_if.ADDR_IN, bus_if.BL, bus_if.WRITE_LENGTH,
                bus_if.GRANT_ID, bus_if.GNT1, bus_if.GNT0, bus_if.BUSY};
    endfunction

    function automatic logic [33:0] exp_vec();
        return {m_cmd, m_ba, m_addr, m_bl, m_wl, m_gid, m_gnt[1], m_gnt[0], m_active};
    endfunction

    task automatic model_reset();
        m_edge   = 0;
        m_pend   = 0;
        m_active = 1'b0;
        m_is_ref = 1'b0;
        m_last   = 1'b1;
        m_cmd    = CMD_NOP;
        m_ba     = '0;
        m_addr   = '0;
        m_bl     = '0;
        m_wl     = 1'b0;
        m_gid    = 1'b0;
        m_gnt    = 2'b00;
    endtask

    task automatic model_step();
        logic [1:0] req;
        logic [1:0] shown_gnt;
        bit         expire;
        bit         done_ref;
        bit         owner;
        m_edge++;
        expire    = (m_edge % RI) == 0;
        done_ref  = m_active && m_is_ref && bus_if.ACCEPTED;
        shown_gnt = m_gnt;
        m_gnt     = 2'b00;
        if (m_active) begin
            if (bus_if.ACCEPTED) begin
                if (!m_is_ref) begin
                    m_gnt[m_gid] = 1'b1;
                    m_last       = m_gid;
                end
                m_active = 1'b0;
                m_cmd    = CMD_NOP;
            end
        end else if (m_pend > 0) begin
            m_active = 1'b1;
            m_is_ref = 1'b1;
            m_cmd    = CMD_REFRESH;
        end else begin
            req = {bus_if.REQ1, bus_if.REQ0} & ~shown_gnt;
            if (req != 2'b00) begin
                owner    = !(req[0] && (!req[1] || m_last));
                m_active = 1'b1;
                m_is_ref = 1'b0;
                m_gid    = owner;
                m_cmd    = (owner ? bus_if.RW1 : bus_if.RW0) ? CMD_WRITE : CMD_READ;
                m_ba     = owner ? bus_if.BA1   : bus_if.BA0;
                m_addr   = owner ? bus_if.ADDR1 : bus_if.ADDR0;
                m_bl     = owner ? bus_if.BL1   : bus_if.BL0;
                m_wl     = owner ? bus_if.WL1   : bus_if.WL0;
            end
        end
        m_pend = m_pend + int'(expire) - int'(done_ref);
        if (m_pend > PMAX) m_pend = PMAX;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("cycle", 64'(obs_vec()), 64'(exp_vec()));
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        bus_if.REQ0 = 1'b0;  bus_if.REQ1 = 1'b0;
        bus_if.RW0 = 1'b0;   bus_if.RW1 = 1'b0;
        bus_if.BA0 = '0;     bus_if.BA1 = '0;
        bus_if.ADDR0 = '0;   bus_if.ADDR1 = '0;
        bus_if.BL0 = '0;     bus_if.BL1 = '0;
        bus_if.WL0 = 1'b0;   bus_if.WL1 = 1'b0;
        bus_if.ACCEPTED = 1'b0;
    endtask

    task automatic set_req(input int idx, input logic rw, input logic [1:0] ba,
                           input logic [22:0] addr, input logic [1:0] bl, input logic wl);
        if (idx == 0) begin
            bus_if.REQ0 = 1'b1; bus_if.RW0 = rw; bus_if.BA0 = ba;
            bus_if.ADDR0 = addr; bus_if.BL0 = bl; bus_if.WL0 = wl;
        end else begin
            bus_if.REQ1 = 1'b1; bus_if.RW1 = rw; bus_if.BA1 = ba;
            bus_if.ADDR1 = addr; bus_if.BL1 = bl; bus_if.WL1 = wl;
        end
    endtask

    task automatic drop_req(input int idx);
        if (idx == 0) bus_if.REQ0 = 1'b0;
        else          bus_if.REQ1 = 1'b0;
    endtask

    task automatic drive_random_requester(input int idx);
        logic cur;
        cur = (idx == 0) ? bus_if.REQ0 : bus_if.REQ1;
        if (cur && m_gnt[idx]) begin
            drop_req(idx);
        end else if (cur && $urandom_range(0, 59) == 0) begin
            drop_req(idx);
        end else if (!cur && $urandom_range(0, 2) == 0) begin
            set_req(idx, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    23'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
    endtask

    // Asynchronous reset taken just after an edge; outputs must clear without a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        model_reset();
        check("reset_outputs", 64'(obs_vec()), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 64'(obs_vec()), 64'(0));
        rst_n = 1'b1;
    endtask

    // ---------------- directed and random stimulus ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Single write request, accepted after three cycles of holding.
        set_req(0, 1'b1, 2'd2, 23'h012345, 2'd1, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t1_cmd_write", 64'(bus_if.COMMAND), 64'(CMD_WRITE));
            check("t1_addr", 64'(bus_if.ADDR_IN), 64'(23'h012345));
            if (i < 2) tick();
        end
        bus_if.ACCEPTED = 1'b1;
        tick();
        check("t1_gnt0", 64'(bus_if.GNT0), 64'(1));
        check("t1_gnt1_quiet", 64'(bus_if.GNT1), 64'(0));
        check("t1_cmd_nop", 64'(bus_if.COMMAND), 64'(CMD_NOP));
        drop_req(0);
        bus_if.ACCEPTED = 1'b0;
        tick();
        check("t1_pulse_width", 64'(bus_if.GNT0), 64'(0));
        check("t1_stays_nop", 64'(bus_if.COMMAND), 64'(CMD_NOP));

        // Continuous contention: grants alternate starting with requester 0.
        do_reset();
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        set_req(0, 1'b0, 2'd1, 23'h000100, 2'd0, 1'b0);
        set_req(1, 1'b1, 2'd3, 23'h7ABCDE, 2'd2, 1'b1);
        bus_if.ACCEPTED = 1'b1;
        prev_cmd = CMD_NOP;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            tick();
            if (bus_if.COMMAND != CMD_NOP)
                check("t2_nop_gap", 64'(prev_cmd), 64'(CMD_NOP));
            if (bus_if.GNT0 || bus_if.GNT1) begin
                check("t2_grant_order", 64'(bus_if.GNT1), 64'(exp_q.pop_front()));
                check("t2_one_hot", 64'(bus_if.GNT0 & bus_if.GNT1), 64'(0));
            end
            prev_cmd = bus_if.COMMAND;
        end
        check("t2_all_grants", 64'(exp_q.size()), 64'(0));

        // Refresh wins over a read raised right as the interval expires.
        do_reset();
        bus_if.ACCEPTED = 1'b1;
        for (int c = 0; c < RI; c++) tick();
        set_req(1, 1'b0, 2'd1, 23'h055AA5, 2'd3, 1'b0);
        tick();
        check("t3_refresh_first", 64'(bus_if.COMMAND), 64'(CMD_REFRESH));
        tick();
        check("t3_gap", 64'(bus_if.COMMAND), 64'(CMD_NOP));
        tick();
        check("t3_read_next", 64'(bus_if.COMMAND), 64'(CMD_READ));
        check("t3_owner", 64'(bus_if.GRANT_ID), 64'(1));
        tick();
        check("t3_gnt1", 64'(bus_if.GNT1), 64'(1));
        drop_req(1);
        tick();

        // Owed refreshes saturate while the controller stalls.
        do_reset();
        for (int c = 0; c < 80; c++) tick();
        check("t4_ref_held", 64'(bus_if.COMMAND), 64'(CMD_REFRESH));
        for (int c = 0; c < RI && (m_edge % RI) != 1; c++) tick();
        bus_if.ACCEPTED = 1'b1;
        ref_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus_if.COMMAND == CMD_REFRESH) ref_cnt++;
            tick();
        end
        check("t4_refresh_count", 64'(ref_cnt), 64'(PMAX));

        // Interval expiry on the same edge a refresh is accepted keeps the count.
        do_reset();
        for (int c = 0; c < 2 * RI - 1; c++) tick();
        check("t6_ref_waiting", 64'(bus_if.COMMAND), 64'(CMD_REFRESH));
        bus_if.ACCEPTED = 1'b1;
        tick();
        check("t6_accepted", 64'(bus_if.COMMAND), 64'(CMD_NOP));
        bus_if.ACCEPTED = 1'b0;
        tick();
        check("t6_pend_kept", 64'(bus_if.COMMAND), 64'(CMD_REFRESH));
        bus_if.ACCEPTED = 1'b1;
        tick();
        bus_if.ACCEPTED = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("t6_drained", 64'(bus_if.BUSY), 64'(0));
        end

        // Reset while a read awaits acceptance: no grant, then fresh round robin.
        set_req(0, 1'b0, 2'd1, 23'($urandom), 2'd2, 1'b0);
        tick();
        check("t5_issue", 64'(bus_if.COMMAND), 64'(CMD_READ));
        tick();
        do_reset();
        set_req(0, 1'b0, 2'd2, 23'h000ABC, 2'd1, 1'b0);
        set_req(1, 1'b1, 2'd0, 23'h400001, 2'd3, 1'b1);
        bus_if.ACCEPTED = 1'b1;
        tick();
        check("t5_first_winner", 64'(bus_if.GRANT_ID), 64'(0));
        tick();
        check("t5_gnt0", 64'(bus_if.GNT0), 64'(1));
        drop_req(0);
        tick();
        check("t5_second_winner", 64'(bus_if.GRANT_ID), 64'(1));
        tick();
        check("t5_gnt1", 64'(bus_if.GNT1), 64'(1));
        drop_req(1);
        tick();

        // Randomized traffic, including early REQ drops and ACCEPTED while idle.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            drive_random_requester(0);
            drive_random_requester(1);
            bus_if.ACCEPTED = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
